// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Load/use hazard controller for a short in-order pipeline. A three-entry
// scoreboard follows the destination registers of the instructions in EX (E0),
// MEM (E1) and WB (E2). The ID instruction is stalled while any source it reads
// matches a pending writer. The WB entry is ignored when the register file
// forwards same-cycle write data (BYPASS_WB=1).
//
// Parameters
//   BYPASS_WB    1: WB-stage writer never stalls ID; 0: it does
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active low
//   id_valid     ID stage holds a real instruction
//   id_rs/id_rt  ID source register numbers
//   id_rs_used   id_rs is actually read
//   id_rt_used   id_rt is actually read
//   id_regwrite  ID instruction writes id_wreg
//   id_wreg      ID destination register
//   id_jumpi     ID instruction is a taken immediate jump
//   mem_busy     data memory not ready, whole pipeline frozen
//   stall        hold PC and IF/ID, bubble into ID/EX
//   flush_ifid   squash the instruction in IF/ID
//   freeze       hold every pipeline register
//   pend_cnt     number of valid scoreboard entries
//   stall_cycles saturating count of cycles that advanced with a stall
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter bit BYPASS_WB = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_rs_used,
   input  logic        id_rt_used,
   input  logic        id_regwrite,
   input  logic [2:0]  id_wreg,
   input  logic        id_jumpi,
   input  logic        mem_busy,
   output logic        stall,
   output logic        flush_ifid,
   output logic        freeze,
   output logic [1:0]  pend_cnt,
   output logic [15:0] stall_cycles
);

   localparam int NUM_ENTRIES = 3;

   // Scoreboard state: index 0 = EX, 1 = MEM, 2 = WB
   logic [NUM_ENTRIES-1:0] r_valid;
   logic [2:0]             r_reg [NUM_ENTRIES];
   logic [1:0]             r_pend_cnt;
   logic [15:0]            r_stall_cycles;

   logic [NUM_ENTRIES-1:0] w_hit;
   logic                   w_stall;
   logic [NUM_ENTRIES-1:0] w_valid_next;
   logic [2:0]             w_reg_next [NUM_ENTRIES];
   logic [1:0]             w_pend_next;

   // Per-entry RAW match against the sources the ID instruction really reads
   for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_hit
      assign w_hit[gi] = r_valid[gi] &
                         ((id_rs_used & (r_reg[gi] == id_rs)) |
                          (id_rt_used & (r_reg[gi] == id_rt)));
   end

   // The WB entry only matters when the register file cannot forward
   assign w_stall = id_valid &
                    (w_hit[0] | w_hit[1] | (w_hit[2] & (BYPASS_WB == 1'b0)));

   assign stall      = w_stall;
   assign freeze     = mem_busy;
   assign flush_ifid = id_valid & id_jumpi & ~w_stall & ~mem_busy;

   // Next scoreboard contents: shift toward WB when the pipeline moves; a
   // stalled ID instruction becomes a bubble in EX. Reset wins over mem_busy.
   always_comb begin
      w_valid_next = r_valid;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
         w_reg_next[k] = r_reg[k];
      end
      if (!rst) begin
         w_valid_next = '0;
         for (int k = 0; k < NUM_ENTRIES; k++) begin
            w_reg_next[k] = '0;
         end
      end else if (!mem_busy) begin
         w_valid_next[0] = id_valid & id_regwrite & ~w_stall;
         w_reg_next[0]   = id_wreg;
         for (int k = 1; k < NUM_ENTRIES; k++) begin
            w_valid_next[k] = r_valid[k-1];
            w_reg_next[k]   = r_reg[k-1];
         end
      end
   end

   assign w_pend_next = 2'(w_valid_next[0]) + 2'(w_valid_next[1]) +
                        2'(w_valid_next[2]);

   always_ff @(posedge clk) begin
      r_valid    <= w_valid_next;
      r_pend_cnt <= w_pend_next;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
         r_reg[k] <= w_reg_next[k];
      end
   end

   // Only stalls that actually cost an advancing cycle are counted
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (w_stall && !mem_busy && (r_stall_cycles != 16'hFFFF)) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign pend_cnt     = r_pend_cnt;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: BYPASS_WB, default 1, meaning register file forwards same-cycle write data to reads, so the WB-stage entry never causes a stall.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  one clock; reset is synchronous and active-low.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt  input  3 each  ID source register numbers.
REQ-006 id_rs_used, id_rt_used  input  1 each  corresponding source is actually read.
REQ-007 id_regwrite  input  1  ID instruction writes a register.
REQ-008 id_wreg  input  3  ID destination register.
REQ-009 id_jumpi  input  1  ID instruction is a taken immediate jump.
REQ-010 mem_busy  input  1  data memory not ready; whole pipeline frozen this cycle.
REQ-011 stall  output  1  holds PC and IF/ID; ID/EX captures a bubble (drives ID/EX stall input).
REQ-012 flush_ifid  output  1  squash the IF/ID instruction.
REQ-013 freeze  output  1  hold every pipeline register.
REQ-014 pend_cnt  output  2  number of valid scoreboard entries (0-3).
REQ-015 stall_cycles  output  16  saturating count of cycles with stall=1.

Function
REQ-016 Scoreboard: three entries, E0 (EX), E1 (MEM), E2 (WB), each holding {valid, reg[2:0]}.
REQ-017 Hazard on entry k: entry valid and reg equals id_rs with id_rs_used=1, or equals id_rt with id_rt_used=1.
REQ-018 stall = id_valid & (hazard on E0 | hazard on E1 | (hazard on E2 & BYPASS_WB==0)); combinational.
REQ-019 freeze = mem_busy; combinational.
REQ-020 flush_ifid = id_valid & id_jumpi & ~stall & ~mem_busy; combinational.
REQ-021 Advance only when mem_busy=0: E2<=E1, E1<=E0, E0<={id_valid & id_regwrite & ~stall, id_wreg}.
REQ-022 When stall=1 with mem_busy=0, E0 is loaded invalid (bubble) while E1/E2 still shift.
REQ-023 When mem_busy=1, E0-E2 hold; stall and flush_ifid are still evaluated from held state, but flush_ifid is forced to 0.
REQ-024 A jump instruction with id_regwrite=1 (link) enters E0 normally when not stalled.
REQ-025 Maximum RAW stall without bypass = 3 cycles; with BYPASS_WB=1 = 2 cycles.
REQ-026 pend_cnt = registered count of valid bits in E0-E2, updated with the scoreboard.
REQ-027 stall_cycles increments by 1 each rising edge where stall=1 and mem_busy=0, and saturates at 16'hFFFF.
REQ-028 Matching of multiple entries to the same register requires no priority handling; any match stalls.

Reset
REQ-029 rst=0 at a rising edge clears all valid bits, pend_cnt=0, stall_cycles=0; reset overrides mem_busy.
REQ-030 While in reset, stall=0 and flush_ifid=0 follow from the empty scoreboard; freeze still follows mem_busy.
REQ-031 Reset mid-stall fully drops pending entries; the first post-reset cycle sees no hazard.

Verification
REQ-032 Producer r3 (regwrite, wreg=3), then next-cycle consumer rs=3 used, BYPASS_WB=1 -> stall=1 for exactly 2 cycles, then 0; stall_cycles=2.
REQ-033 Same as REQ-032 with BYPASS_WB=0 -> stall=1 for 3 cycles; pend_cnt sequence 1,1,1,0 after bubbles drain.
REQ-034 Consumer rt=5 with id_rt_used=0 behind writer of r5 -> stall=0, no bubble.
REQ-035 Writer r2 in E0, mem_busy=1 for 4 cycles, consumer of r2 in ID -> freeze=1 for 4 cycles, scoreboard held, stall=1 throughout, stall_cycles unchanged; after release, normal 2-cycle drain.
REQ-036 id_jumpi=1, id_valid=1, no hazard -> flush_ifid=1 for that cycle; same with hazard -> flush_ifid=0 until the stall clears.
REQ-037 Three back-to-back writers r1,r2,r3, then rst=0 for one cycle -> pend_cnt=0, stall_cycles=0, consumer of r1 next cycle sees stall=0.
